// File: rtl/serial_chunk_adder_pkg.sv
// rtl/serial_chunk_adder_pkg.sv - shared types and helpers for serial_chunk_adder
//
// Purpose: FSM state encoding and the counter-width helper used by the
//          serial adder top.
// Ports:   none (package)

package serial_chunk_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits needed to count 0..n-1. Never returns less than 1, so a
  // single-chunk configuration still gets a legal counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_fa.sv
// rtl/serial_chunk_adder_fa.sv - gate-level half and full adder cells
//
// Purpose: single-bit adder cells forming the ripple chain of the serial adder.
// Ports (half_adder): a_i, b_i -> s_o (sum), co_o (carry)
// Ports (full_adder): a_i, b_i, ci_i -> s_o (sum), co_o (carry)

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i;
  assign co_o = a_i & b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i),  .s_o(s1),  .co_o(c1));
  half_adder u_ha1 (.a_i(s1),  .b_i(ci_i), .s_o(s_o), .co_o(c2));

  assign co_o = c1 | c2;
endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder, CHUNK bits per clock
//
// Purpose: computes {cout,sum} = a + b + cin over WIDTH/CHUNK cycles using a
//          ripple chain of CHUNK full adders, with a start/busy/done handshake.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous reset, active-high
//   start in  1      capture a, b, cin (accepted only when busy=0)
//   a     in  WIDTH  operand A
//   b     in  WIDTH  operand B
//   cin   in  1      carry-in
//   busy  out 1      add in progress
//   done  out 1      one-cycle pulse when sum/cout become valid
//   sum   out WIDTH  result, held until the next accepted start
//   cout  out 1      final carry-out, held with sum

module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = clog2_min1(NCHUNK);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               cout_q;

  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   chunk_ext;
  logic [CHUNK-1:0]   chain_sum;
  logic [CHUNK:0]     carry_chain;
  logic               chain_co;
  logic               last_chunk;

  // Ripple chain over the low CHUNK bits of the operand shift registers.
  assign carry_chain[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    full_adder u_fa (
      .a_i (a_q[i]),
      .b_i (b_q[i]),
      .ci_i(carry_chain[i]),
      .s_o (chain_sum[i]),
      .co_o(carry_chain[i+1])
    );
  end

  assign chain_co   = carry_chain[CHUNK];
  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  // Results enter from the MSB side so that after NCHUNK shifts the first
  // (least significant) chunk has reached bit 0. Written with shifts rather
  // than slices so CHUNK == WIDTH needs no special case.
  always_comb begin
    chunk_ext                = '0;
    chunk_ext[CHUNK-1:0]     = chain_sum;
    a_d                      = a_q >> CHUNK;
    b_d                      = b_q >> CHUNK;
    sum_d                    = (chunk_ext << (WIDTH - CHUNK)) | (sum_q >> CHUNK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // start is deliberately not looked at here: in-flight operands
          // must not be disturbed.
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= chain_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            cout_q  <= chain_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - directed bench for serial_chunk_adder, CHUNK = 1,2,4,8

module tb_serial_chunk_adder;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] start;
  logic [3:0] cin;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] cout;
  logic [7:0] a_w   [4];
  logic [7:0] b_w   [4];
  logic [7:0] sum_w [4];

  int n_checks;
  int n_pass;

  // DUT g has CHUNK = 1<<g, so NCHUNK = 8>>g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_chunk_adder #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
      .clk  (clk),
      .rst  (rst[g]),
      .start(start[g]),
      .a    (a_w[g]),
      .b    (b_w[g]),
      .cin  (cin[g]),
      .busy (busy[g]),
      .done (done[g]),
      .sum  (sum_w[g]),
      .cout (cout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an add on DUT d and wait for done; checks latency, sum and cout.
  task automatic do_add(input int d, input logic [7:0] aa, input logic [7:0] bb,
                        input logic ci, input int exp_cyc, input logic [7:0] exp_sum,
                        input logic exp_cout, input string tag);
    int cyc;
    a_w[d]   = aa;
    b_w[d]   = bb;
    cin[d]   = ci;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    a_w[d]   = ~aa;
    b_w[d]   = ~bb;
    cin[d]   = ~ci;
    check({tag, " busy"}, busy[d], 1'b1);
    cyc = 0;
    while (!done[d] && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " sum"}, sum_w[d], exp_sum);
    check({tag, " cout"}, cout[d], exp_cout);
    check({tag, " busy_end"}, busy[d], 1'b0);
  endtask

  initial begin
    int pulses;
    logic [8:0] exp9;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    n_checks = 0;
    n_pass   = 0;
    rst      = 4'hF;
    start    = 4'h0;
    cin      = 4'h0;
    for (int i = 0; i < 4; i++) begin
      a_w[i] = 8'h00;
      b_w[i] = 8'h00;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("reset busy", busy[i], 1'b0);
      check("reset done", done[i], 1'b0);
      check("reset sum", sum_w[i], 8'h00);
      check("reset cout", cout[i], 1'b0);
    end
    rst = 4'h0;
    tick();

    do_add(0, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, "c1 ff+01");
    do_add(2, 8'h3C, 8'h5A, 1'b1, 2, 8'h97, 1'b0, "c4 3c+5a+1");
    do_add(3, 8'h80, 8'h80, 1'b1, 1, 8'h01, 1'b1, "c8 80+80+1");

    // start pulsed mid-run on CHUNK=2 must be ignored
    a_w[1] = 8'h10; b_w[1] = 8'h01; cin[1] = 1'b0; start[1] = 1'b1;
    tick();
    check("ign busy0", busy[1], 1'b1);
    a_w[1] = 8'hFF; b_w[1] = 8'hFF; start[1] = 1'b1;
    tick();
    check("ign busy1", busy[1], 1'b1);
    start[1] = 1'b0;
    tick();
    check("ign busy2", busy[1], 1'b1);
    tick();
    check("ign busy3", busy[1], 1'b1);
    check("ign nodone3", done[1], 1'b0);
    tick();
    check("ign done", done[1], 1'b1);
    check("ign sum", sum_w[1], 8'h11);
    check("ign cout", cout[1], 1'b0);

    // reset in the middle of a bit-serial add
    a_w[0] = 8'hFF; b_w[0] = 8'h01; cin[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("rst busy", busy[0], 1'b0);
    check("rst done", done[0], 1'b0);
    check("rst sum", sum_w[0], 8'h00);
    check("rst cout", cout[0], 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done[0]) pulses++;
    end
    check("rst no done", pulses, 0);
    do_add(0, 8'h12, 8'h34, 1'b0, 8, 8'h46, 1'b0, "c1 after rst");

    // back-to-back: second start issued in the done cycle
    do_add(2, 8'hF0, 8'h0F, 1'b1, 2, 8'h00, 1'b1, "c4 b2b first");
    do_add(2, 8'h01, 8'h02, 1'b0, 2, 8'h03, 1'b0, "c4 b2b second");
    do_add(0, 8'hAA, 8'h55, 1'b0, 8, 8'hFF, 1'b0, "c1 b2b first");
    do_add(0, 8'h01, 8'h02, 1'b0, 8, 8'h03, 1'b0, "c1 b2b second");

    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 3; k++) begin
        ra   = 8'($urandom_range(0, 255));
        rb   = 8'($urandom_range(0, 255));
        rc   = 1'($urandom_range(0, 1));
        exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
        do_add(d, ra, rb, rc, 8 >> d, exp9[7:0], exp9[8], "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
